// File: rtl/cascade_cmp_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cascade_cmp_pkg
//  Description : Shared constants and helpers for the compare-gated cascade
//                counter. Holds the counter mode constants, the counter
//                state encoding and the terminal-count helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package cascade_cmp_pkg;

  // Counter behaviour at terminal count
  localparam bit CNT_WRAP = 1'b1;  // MAX -> 0
  localparam bit CNT_SAT  = 1'b0;  // hold MAX

  // Counter state classification (derived from the count value)
  typedef enum logic [1:0] {
    CNT_IDLE     = 2'd0,  // CNT == 0
    CNT_COUNTING = 2'd1,  // 0 < CNT < MAX
    CNT_TERM     = 2'd2   // CNT == MAX
  } cnt_state_e;

  // Terminal count of a cw-bit counter, 2^cw - 1 (cw <= 31)
  function automatic logic [31:0] cnt_max(input int unsigned cw);
    return (32'd1 << cw) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cascade_cmp_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cascade_cmp_counter_if
//  Description : Control/status bundle of the compare-gated cascade counter.
//  Ports       : none; signals grouped into modports
//                slave  - seen by the counter (inputs sel/ld/a/b/ref_ld/
//                         ref_in/en/clr/arm, outputs cnt/gt/tc/flag)
//                master - seen by the driving environment (mirror image)
//  Revision    : 1.0 - initial release
// ============================================================================
interface cascade_cmp_counter_if #(
  parameter int unsigned W  = 5,
  parameter int unsigned CW = 11
);

  logic          sel_i;     // source select: 1 = A, 0 = B
  logic          ld_i;      // load operand register
  logic [W-1:0]  a_i;       // source bus A
  logic [W-1:0]  b_i;       // source bus B
  logic          ref_ld_i;  // load reference register
  logic [W-1:0]  ref_in_i;  // reference value
  logic          en_i;      // count enable
  logic          clr_i;     // synchronous counter clear
  logic          arm_i;     // enables flag toggling
  logic [CW-1:0] cnt_o;     // counter value
  logic          gt_o;      // registered compare result
  logic          tc_o;      // counter at terminal count
  logic          flag_o;    // terminal-count toggle

  modport slave (
    input  sel_i, ld_i, a_i, b_i, ref_ld_i, ref_in_i, en_i, clr_i, arm_i,
    output cnt_o, gt_o, tc_o, flag_o
  );

  modport master (
    output sel_i, ld_i, a_i, b_i, ref_ld_i, ref_in_i, en_i, clr_i, arm_i,
    input  cnt_o, gt_o, tc_o, flag_o
  );

endinterface
`default_nettype wire

// File: rtl/cascade_cmp_counter_src_cmp_stage.sv
`default_nettype none
// ============================================================================
//  Module      : src_cmp_stage
//  Description : Operand source mux, operand register OPR, reference register
//                REF and the registered unsigned compare GT_Q = (OPR > REF).
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                sel_i, ld_i      - source select and operand load
//                a_i, b_i         - source buses
//                ref_ld_i,
//                ref_in_i         - reference load and value
//                gt_o             - registered compare result
//  Revision    : 1.0 - initial release
// ============================================================================
module src_cmp_stage #(
  parameter int unsigned W = 5
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         sel_i,
  input  wire logic         ld_i,
  input  wire logic [W-1:0] a_i,
  input  wire logic [W-1:0] b_i,
  input  wire logic         ref_ld_i,
  input  wire logic [W-1:0] ref_in_i,
  output logic              gt_o
);

  logic [W-1:0] opr_q;
  logic [W-1:0] opr_d;
  logic [W-1:0] ref_q;
  logic [W-1:0] ref_d;
  logic         gt_q;
  logic         gt_d;

  always_comb begin
    opr_d = opr_q;
    ref_d = ref_q;
    if (ld_i) begin
      opr_d = sel_i ? a_i : b_i;
    end
    if (ref_ld_i) begin
      ref_d = ref_in_i;
    end
    // Compare uses the current register contents, so a load takes one
    // further edge to reach GT_Q.
    gt_d = (opr_q > ref_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opr_q <= '0;
      ref_q <= '0;
      gt_q  <= 1'b0;
    end else begin
      opr_q <= opr_d;
      ref_q <= ref_d;
      gt_q  <= gt_d;
    end
  end

  assign gt_o = gt_q;

endmodule
`default_nettype wire

// File: rtl/cascade_cmp_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cascade_cmp_counter
//  Description : Compare-gated event counter. A selected operand is
//                registered and compared against a loadable reference; every
//                enabled cycle with a registered "greater than" advances a
//                CW-bit counter that wraps or saturates at MAX. A toggle flag
//                marks each increment that enters MAX while armed.
//  Ports       : clk, rst - clock, synchronous active-high reset
//                ctl_if   - cascade_cmp_counter_if.slave
//                           in : sel, ld, a, b, ref_ld, ref_in, en, clr, arm
//                           out: cnt, gt (registered), tc (CNT==MAX,
//                                combinational), flag (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module cascade_cmp_counter
  import cascade_cmp_pkg::*;
#(
  parameter int unsigned W    = 5,
  parameter int unsigned CW   = 11,
  parameter bit          WRAP = CNT_WRAP
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  cascade_cmp_counter_if.slave       ctl_if
);

  localparam logic [31:0]   c_max32  = cnt_max(CW);
  localparam logic [CW-1:0] c_max    = c_max32[CW-1:0];
  localparam logic [CW-1:0] c_one    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] c_max_m1 = c_max - c_one;

  logic          w_gt;
  logic          w_inc;
  logic          w_tc_event;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          flag_q;
  logic          flag_d;

  src_cmp_stage #(
    .W (W)
  ) u_src_cmp (
    .clk      (clk),
    .rst      (rst),
    .sel_i    (ctl_if.sel_i),
    .ld_i     (ctl_if.ld_i),
    .a_i      (ctl_if.a_i),
    .b_i      (ctl_if.b_i),
    .ref_ld_i (ctl_if.ref_ld_i),
    .ref_in_i (ctl_if.ref_in_i),
    .gt_o     (w_gt)
  );

  // CLR suppresses the increment, so a clear never produces a tc_event.
  assign w_inc      = ctl_if.en_i & w_gt & ~ctl_if.clr_i;
  // Only the step from MAX-1 into MAX counts; a saturated counter sitting at
  // MAX does not re-fire.
  assign w_tc_event = w_inc & (cnt_q == c_max_m1);

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q ^ (w_tc_event & ctl_if.arm_i);
    if (ctl_if.clr_i) begin
      cnt_d = '0;
    end else if (w_inc) begin
      if (cnt_q == c_max) begin
        cnt_d = (WRAP == CNT_WRAP) ? '0 : c_max;
      end else begin
        cnt_d = cnt_q + c_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign ctl_if.cnt_o  = cnt_q;
  assign ctl_if.gt_o   = w_gt;
  assign ctl_if.tc_o   = (cnt_q == c_max);
  assign ctl_if.flag_o = flag_q;

endmodule
`default_nettype wire
